alu_seq: RTL and testbench

- Parametrised, clocked successor to the team's 4-bit combinational ALU.
- Same 16-entry opcode map, generalised to WIDTH bits, plus sign and overflow flags.
- MUL and DIV are iterative multi-cycle units that also return a high word (product high half / remainder).
- Operands enter through a valid/ready input handshake; results leave through a valid/ready output handshake, so the block drops into streaming datapaths with backpressure.

---
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Purpose : operand/result handshake bundle for alu_seq (input and output valid/ready channels).
// Latency : none, wiring only.
// Backpressure: carries in_ready toward the source and out_ready from the consumer.
//
// Signals:
//   in_valid/in_ready  : operand channel handshake; a, b, opcode qualified by in_valid
//   out_valid/out_ready: result channel handshake; result, result_hi and flags qualified by out_valid
//   master = operand source / result consumer, slave = the ALU
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             carry_flag;
   logic             zero_flag;
   logic             neg_flag;
   logic             ovf_flag;

   modport master (
      output in_valid, a, b, opcode, out_ready,
      input  in_ready, out_valid, result, result_hi,
             carry_flag, zero_flag, neg_flag, ovf_flag
   );

   modport slave (
      input  in_valid, a, b, opcode, out_ready,
      output in_ready, out_valid, result, result_hi,
             carry_flag, zero_flag, neg_flag, ovf_flag
   );
endinterface

// File: rtl/alu_seq.sv
// Purpose : WIDTH-bit clocked ALU, 16-entry opcode map, iterative MUL (shift-add) and DIV (restoring).
// Latency : 1 cycle accept->out_valid for single-cycle ops and DIV by zero; WIDTH+1 for MUL and DIV.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so at most 1 op per 2 cycles.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any operation in flight
//   bus   : alu_seq_if slave modport (operand channel in, result/flags channel out)
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOT  = 4'b0100;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_DIV  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_LSL  = 4'b1000;
   localparam logic [3:0] OP_LSR  = 4'b1001;
   localparam logic [3:0] OP_ASR  = 4'b1010;
   localparam logic [3:0] OP_ROL  = 4'b1011;
   localparam logic [3:0] OP_ROR  = 4'b1100;
   localparam logic [3:0] OP_PASS = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_nx;

   // captured operation context for the iterative units
   logic [3:0]       op_code_q;
   logic [WIDTH-1:0] op_b_q;
   logic [CW-1:0]    cnt_q;

   // MUL: {hi_q,lo_q} is the partial product, lo_q shifting out multiplier bits.
   // DIV: hi_q is the partial remainder, lo_q shifts dividend bits out and quotient bits in.
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   // registered outputs
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_hi_q;
   logic             carry_q;
   logic             zero_q;
   logic             neg_q;
   logic             ovf_q;

   logic             accept;
   logic             iter_op;
   logic             last_iter;

   // single-cycle datapath, evaluated on the live inputs at the accept edge
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_c;
   logic             sc_v;

   // one step of the iterative units
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nx;
   logic [WIDTH-1:0] mul_lo_nx;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [WIDTH-1:0] div_hi_nx;
   logic [WIDTH-1:0] div_lo_nx;
   logic [WIDTH-1:0] it_hi;
   logic [WIDTH-1:0] it_lo;
   logic             it_is_mul;

   assign accept    = bus.in_valid && (state_q == IDLE);
   // DIV by zero short-circuits to a single-cycle result
   assign iter_op   = (bus.opcode == OP_MUL) ||
                      ((bus.opcode == OP_DIV) && (bus.b != '0));
   assign last_iter = (cnt_q == CW'(1));
   assign it_is_mul = (op_code_q == OP_MUL);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   always_comb begin
      state_nx      = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nx = iter_op ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (last_iter) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            // no re-accept in the handshake cycle; in_ready returns next cycle
            if (bus.out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Single-cycle operations
   // ------------------------------------------------------------------
   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (bus.opcode)
         OP_ADD: begin
            {sc_c, sc_res} = {1'b0, bus.a} + {1'b0, bus.b};
            sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                   (sc_res[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = bus.a - bus.b;
            sc_c   = (bus.a < bus.b);
            sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (sc_res[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  sc_res = bus.a & bus.b;
         OP_OR:   sc_res = bus.a | bus.b;
         OP_NOT:  sc_res = ~bus.a;
         OP_XOR:  sc_res = bus.a ^ bus.b;
         OP_LSL:  sc_res = {bus.a[WIDTH-2:0], 1'b0};
         OP_LSR:  sc_res = {1'b0, bus.a[WIDTH-1:1]};
         OP_ASR:  sc_res = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
         OP_ROL:  sc_res = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
         OP_ROR:  sc_res = {bus.a[0], bus.a[WIDTH-1:1]};
         OP_PASS: sc_res = bus.a;
         OP_DIV: begin
            // only reached with b == 0: quotient 0, remainder a, carry flags the fault
            sc_hi = bus.a;
            sc_c  = 1'b1;
         end
         default: begin
            sc_res = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Iteration step (MUL shift-add / DIV restoring)
   // ------------------------------------------------------------------
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_b_q} : '0);
      mul_hi_nx = mul_sum[WIDTH:1];
      mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, op_b_q});
      // when div_ge holds the difference is below b, so WIDTH bits suffice
      div_diff  = div_shift[WIDTH-1:0] - op_b_q;
      div_hi_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_lo_nx = {lo_q[WIDTH-2:0], div_ge};

      it_hi = it_is_mul ? mul_hi_nx : div_hi_nx;
      it_lo = it_is_mul ? mul_lo_nx : div_lo_nx;
   end

   // ------------------------------------------------------------------
   // Datapath and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_code_q <= '0;
         op_b_q    <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         res_q     <= '0;
         res_hi_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b1;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (accept) begin
         op_code_q <= bus.opcode;
         op_b_q    <= bus.b;
         if (iter_op) begin
            hi_q  <= '0;
            lo_q  <= bus.a;
            cnt_q <= CW'(WIDTH);
         end else begin
            res_q    <= sc_res;
            res_hi_q <= sc_hi;
            carry_q  <= sc_c;
            zero_q   <= (sc_res == '0);
            neg_q    <= sc_res[WIDTH-1];
            ovf_q    <= sc_v;
         end
      end else if (state_q == BUSY) begin
         hi_q  <= it_hi;
         lo_q  <= it_lo;
         cnt_q <= cnt_q - CW'(1);
         // the final step lands straight in the output registers
         if (last_iter) begin
            res_q    <= it_lo;
            res_hi_q <= it_hi;
            carry_q  <= it_is_mul && (it_hi != '0);
            zero_q   <= (it_lo == '0);
            neg_q    <= it_lo[WIDTH-1];
            ovf_q    <= 1'b0;
         end
      end
   end

   assign bus.result     = res_q;
   assign bus.result_hi  = res_hi_q;
   assign bus.carry_flag = carry_q;
   assign bus.zero_flag  = zero_q;
   assign bus.neg_flag   = neg_q;
   assign bus.ovf_flag   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed cases, reset abort, backpressure and randomized ops
// against an arithmetic reference model.
module tb_alu_seq;
   localparam int W = 8;
   localparam int TMO = 100;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {result, result_hi, carry, zero, neg, ovf}
   logic [2*W+3:0] obs;
   assign obs = {bus.result, bus.result_hi, bus.carry_flag,
                 bus.zero_flag, bus.neg_flag, bus.ovf_flag};

   function automatic logic [2*W+3:0] pack(input logic [W-1:0] r, input logic [W-1:0] h,
                                           input logic c, input logic z, input logic n,
                                           input logic v);
      return {r, h, c, z, n, v};
   endfunction

   // Reference: opcode rules as plain unsigned / signed integer arithmetic.
   function automatic logic [2*W+3:0] model(input logic [3:0] op, input longint unsigned a,
                                            input longint unsigned b);
      longint unsigned m = 64'd1 << W;
      longint unsigned half = m / 2;
      longint unsigned r = 0;
      longint unsigned h = 0;
      longint unsigned p;
      longint sa, sb, s, hs;
      bit c = 0;
      bit v = 0;
      hs = longint'(half);
      sa = (a >= half) ? longint'(a) - longint'(m) : longint'(a);
      sb = (b >= half) ? longint'(b) - longint'(m) : longint'(b);
      case (op)
         4'd0: begin r = (a + b) % m; c = (a + b) >= m; s = sa + sb; v = (s < -hs) || (s >= hs); end
         4'd1: begin r = (a + m - b) % m; c = a < b; s = sa - sb; v = (s < -hs) || (s >= hs); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = m - 1 - a;
         4'd5: begin p = a * b; r = p % m; h = p / m; c = (h != 0); end
         4'd6: begin
            if (b == 0) begin r = 0; h = a; c = 1; end
            else begin r = a / b; h = a % b; end
         end
         4'd7: r = a ^ b;
         4'd8: r = (a * 2) % m;
         4'd9: r = a / 2;
         4'd10: r = a / 2 + ((a >= half) ? half : 0);
         4'd11: r = (a * 2) % m + a / half;
         4'd12: r = a / 2 + (a % 2) * half;
         4'd15: r = a;
         default: r = 0;
      endcase
      return pack(W'(r), W'(h), c, (r == 0), (r >= half), v);
   endfunction

   function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
      if (op == 4'd5 || (op == 4'd6 && b != '0)) return W + 1;
      return 1;
   endfunction

   // Drive one operation, measure accept->out_valid latency, capture outputs, then retire it.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W+3:0] o, output int lat, output bit rdy_bad);
      int n;
      rdy_bad = 0;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.opcode    = op;
      bus.out_ready = 1'b0;
      n = 0;
      while (!bus.in_ready && n < TMO) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      // scramble the inputs: the block must work from its captured copy
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.opcode   = 4'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < TMO) begin
         if (bus.in_ready) rdy_bad = 1;
         @(negedge clk);
         lat++;
      end
      if (bus.in_ready) rdy_bad = 1;
      o = obs;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bit spurious;
      @(negedge clk);
      checks++;
      if (obs !== pack(8'h00, 8'h00, 0, 1, 0, 0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: obs=%h ov=%b ir=%b, need obs=%h ov=0 ir=1",
                  obs, bus.out_valid, bus.in_ready, pack(8'h00, 8'h00, 0, 1, 0, 0));
      end
      // start DIV 200/7 and abort it mid-iteration
      bus.in_valid = 1'b1; bus.a = 8'd200; bus.b = 8'd7; bus.opcode = 4'b0110; bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy_before: in_ready=%b need 0", bus.in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs !== pack(8'h00, 8'h00, 0, 1, 0, 0)) begin
         failures++;
         $display("FAIL reset_abort: ov=%b ir=%b obs=%h, need ov=0 ir=1 obs=%h",
                  bus.out_valid, bus.in_ready, obs, pack(8'h00, 8'h00, 0, 1, 0, 0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) spurious = 1;
      end
      checks++;
      if (spurious) begin
         failures++;
         $display("FAIL reset_no_spurious: out_valid/in_ready moved after abort (ov=%b ir=%b) need 0/1",
                  bus.out_valid, bus.in_ready);
      end
      bus.out_ready = 1'b0;
      begin
         logic [2*W+3:0] o;
         int lat;
         bit rb;
         run_op(4'b0000, 8'd1, 8'd1, o, lat, rb);
         checks++;
         if (o !== pack(8'h02, 8'h00, 0, 0, 0, 0) || lat !== 1) begin
            failures++;
            $display("FAIL reset_then_add: obs=%h lat=%0d need obs=%h lat=1",
                     o, lat, pack(8'h02, 8'h00, 0, 0, 0, 0));
         end
      end
   endtask

   typedef struct {
      logic [3:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W+3:0] exp;
      int             lat;
   } dir_t;

   task automatic test_directed();
      dir_t tbl[10];
      logic [2*W+3:0] o;
      int lat;
      bit rb;
      tbl[0] = '{4'b0000, 8'h7F, 8'h01, pack(8'h80, 8'h00, 0, 0, 1, 1), 1};
      tbl[1] = '{4'b0000, 8'hFF, 8'h01, pack(8'h00, 8'h00, 1, 1, 0, 0), 1};
      tbl[2] = '{4'b0001, 8'h03, 8'h05, pack(8'hFE, 8'h00, 1, 0, 1, 0), 1};
      tbl[3] = '{4'b1011, 8'h81, 8'h5A, pack(8'h03, 8'h00, 0, 0, 0, 0), 1};
      tbl[4] = '{4'b1010, 8'h80, 8'h11, pack(8'hC0, 8'h00, 0, 0, 1, 0), 1};
      tbl[5] = '{4'b1101, 8'hA5, 8'h3C, pack(8'h00, 8'h00, 0, 1, 0, 0), 1};
      tbl[6] = '{4'b0101, 8'd200, 8'd3, pack(8'h58, 8'h02, 1, 0, 0, 0), 9};
      tbl[7] = '{4'b0101, 8'd15, 8'd17, pack(8'hFF, 8'h00, 0, 0, 1, 0), 9};
      tbl[8] = '{4'b0110, 8'd200, 8'd7, pack(8'h1C, 8'h04, 0, 0, 0, 0), 9};
      tbl[9] = '{4'b0110, 8'd9, 8'd0, pack(8'h00, 8'h09, 1, 1, 0, 0), 1};
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, o, lat, rb);
         checks++;
         if (o !== tbl[i].exp) begin
            failures++;
            $display("FAIL directed_%0d_value: op=%b a=%h b=%h obs=%h need %h",
                     i, tbl[i].op, tbl[i].a, tbl[i].b, o, tbl[i].exp);
         end
         checks++;
         if (lat !== tbl[i].lat || rb) begin
            failures++;
            $display("FAIL directed_%0d_latency: lat=%0d in_ready_while_busy=%b need lat=%0d and 0",
                     i, lat, rb, tbl[i].lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [2*W+3:0] exp1, exp2;
      logic [W-1:0] a2, b2;
      bit moved;
      a2 = W'($urandom);
      b2 = W'($urandom);
      exp1 = model(4'b0111, 64'h5C, 64'h33);
      exp2 = model(4'b0000, a2, b2);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 8'h5C; bus.b = 8'h33; bus.opcode = 4'b0111; bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.a = a2; bus.b = b2; bus.opcode = 4'b0000;   // new request held while DONE stalls
      moved = 0;
      repeat (3) begin
         if (obs !== exp1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) moved = 1;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (moved || obs !== exp1) begin
         failures++;
         $display("FAIL bp_hold: obs=%h ov=%b ir=%b need obs=%h ov=1 ir=0 throughout",
                  obs, bus.out_valid, bus.in_ready, exp1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: ov=%b ir=%b need ov=0 ir=1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== exp2) begin
         failures++;
         $display("FAIL bp_pending_taken: ov=%b obs=%h need ov=1 obs=%h", bus.out_valid, obs, exp2);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [2*W+3:0] o, e;
      logic [3:0] op;
      logic [W-1:0] a, b;
      int lat;
      bit rb;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         if (i % 3 == 0) op = ($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b0110;
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         e = model(op, a, b);
         run_op(op, a, b, o, lat, rb);
         checks++;
         if (o !== e || lat !== model_lat(op, b) || rb) begin
            failures++;
            $display("FAIL random_%0d: op=%b a=%h b=%h obs=%h lat=%0d rdy_bad=%b need obs=%h lat=%0d",
                     i, op, a, b, o, lat, rb, e, model_lat(op, b));
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.opcode = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
